// File: rtl/alu_share_arbiter_pkg.sv
// alu_arb_pkg
//   Shared definitions for the two-requester ALU sharing arbiter:
//   FSM state encoding, the 6-bit ALUControl opcodes understood by the
//   shared ALU, the default ALU latency and a one-hot helper.
//   No ports (package).
package alu_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } arb_state_t;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_SLT = 6'b101010;

   localparam int ALU_LAT_DEFAULT = 1;

   // Requester index -> one-hot 2-bit vector.
   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// rr_arbiter_2
//   Two-way round-robin grant logic (purely combinational).
//   Ports:
//     req  [1:0] in  : request bits, bit i = requester i
//     last       in  : index of the requester granted most recently
//     gnt  [1:0] out : one-hot grant (all zero when nobody requests)
//   A lone requester always wins; on a tie the one that was not granted
//   last time wins.
module rr_arbiter_2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   // Grant selection from the request pattern and previous winner.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one ALU between two requesters. A request is accepted in IDLE,
//   its operands are held on the ALU for ALU_LAT cycles (EXEC), the result
//   is captured and offered back to the owning requester (RESP) until it
//   is accepted, after which the arbiter returns to IDLE.
//   Optional build macro: ALU_ARB_STATS_EN enables saturating per-requester
//   grant counters; without it GrantCnt0/GrantCnt1 are tied to zero.
//   Ports:
//     Clk, Reset (async, active-high)
//     ReqValid/ReqReady [1:0]     : request handshake per requester
//     ReqOp [11:0], ReqA/ReqB [63:0] : per-requester opcode / operands
//     RspValid/RspReady [1:0]     : response handshake (RspValid one-hot)
//     RspResult [31:0], RspZero   : response data
//     ALUControl, ALUA, ALUB      : drive the shared ALU
//     ALUResult, ALUZero          : returned by the shared ALU
//     Busy                        : high whenever not IDLE
//     GrantCnt0/GrantCnt1 [15:0]  : grant statistics
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int ALU_LAT = ALU_LAT_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [1:0]  ReqValid,
   output logic [1:0]  ReqReady,
   input  logic [11:0] ReqOp,
   input  logic [63:0] ReqA,
   input  logic [63:0] ReqB,
   output logic [1:0]  RspValid,
   input  logic [1:0]  RspReady,
   output logic [31:0] RspResult,
   output logic        RspZero,
   output logic [5:0]  ALUControl,
   output logic [31:0] ALUA,
   output logic [31:0] ALUB,
   input  logic [31:0] ALUResult,
   input  logic        ALUZero,
   output logic        Busy,
   output logic [15:0] GrantCnt0,
   output logic [15:0] GrantCnt1
);

   localparam logic [2:0] LAT_C = ALU_LAT[2:0];

   arb_state_t state_r;
   arb_state_t state_next_s;
   logic [2:0] cnt_r;
   logic       gnt_idx_r;
   logic       last_grant_r;
   logic [1:0] gnt_s;
   logic       grant_fire_s;

   rr_arbiter_2 u_rr (
      .req  (ReqValid),
      .last (last_grant_r),
      .gnt  (gnt_s)
   );

   assign grant_fire_s = (state_r == ST_IDLE) && (ReqValid != 2'b00);

   // FSM state register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (ReqValid != 2'b00) begin
               state_next_s = ST_EXEC;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (cnt_r == 3'd1) begin
               state_next_s = ST_RESP;
            end else begin
               state_next_s = ST_EXEC;
            end
         end
         ST_RESP: begin
            // Only the owner's RspReady completes the handshake.
            if (RspReady[gnt_idx_r]) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_RESP;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM outputs: request accept and busy flag.
   always_comb begin
      ReqReady = 2'b00;
      Busy     = (state_r != ST_IDLE);
      if ((state_r == ST_IDLE) && !Reset) begin
         ReqReady = gnt_s;
      end else begin
         ReqReady = 2'b00;
      end
   end

   // Datapath: operand capture at grant, latency countdown, result capture.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ALUControl   <= 6'b000000;
         ALUA         <= 32'h0000_0000;
         ALUB         <= 32'h0000_0000;
         RspResult    <= 32'h0000_0000;
         RspZero      <= 1'b0;
         RspValid     <= 2'b00;
         cnt_r        <= 3'd0;
         gnt_idx_r    <= 1'b0;
         last_grant_r <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_fire_s) begin
                  ALUControl   <= gnt_s[1] ? ReqOp[11:6]  : ReqOp[5:0];
                  ALUA         <= gnt_s[1] ? ReqA[63:32]  : ReqA[31:0];
                  ALUB         <= gnt_s[1] ? ReqB[63:32]  : ReqB[31:0];
                  cnt_r        <= LAT_C;
                  gnt_idx_r    <= gnt_s[1];
                  last_grant_r <= gnt_s[1];
               end
            end
            ST_EXEC: begin
               cnt_r <= cnt_r - 3'd1;
               // Counter at 1 marks the cycle the ALU output is valid.
               if (cnt_r == 3'd1) begin
                  RspResult <= ALUResult;
                  RspZero   <= ALUZero;
                  RspValid  <= onehot2(gnt_idx_r);
               end
            end
            ST_RESP: begin
               if (RspReady[gnt_idx_r]) begin
                  RspValid <= 2'b00;
               end
            end
            default: begin
               RspValid <= 2'b00;
            end
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [15:0] grant_cnt0_r;
   logic [15:0] grant_cnt1_r;

   // Saturating grant counters, one per requester.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         grant_cnt0_r <= 16'h0000;
         grant_cnt1_r <= 16'h0000;
      end else begin
         if (grant_fire_s && gnt_s[0] && (grant_cnt0_r != 16'hFFFF)) begin
            grant_cnt0_r <= grant_cnt0_r + 16'h0001;
         end
         if (grant_fire_s && gnt_s[1] && (grant_cnt1_r != 16'hFFFF)) begin
            grant_cnt1_r <= grant_cnt1_r + 16'h0001;
         end
      end
   end

   assign GrantCnt0 = grant_cnt0_r;
   assign GrantCnt1 = grant_cnt1_r;
`else
   assign GrantCnt0 = 16'h0000;
   assign GrantCnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Self-checking bench for alu_share_arbiter with a behavioural shared ALU.
//   Covers reset state, a table of single operations, simultaneous
//   requests, a stalled response, reset during EXEC, the grant counters
//   and a randomized run checked against a transaction-level model.
module tb_alu_share_arbiter;
   import alu_arb_pkg::*;

   localparam int LAT = 1;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [1:0]  ReqValid, ReqReady, RspValid, RspReady;
   logic [11:0] ReqOp;
   logic [63:0] ReqA, ReqB;
   logic [31:0] RspResult, ALUA, ALUB, ALUResult;
   logic        RspZero, ALUZero, Busy;
   logic [5:0]  ALUControl;
   logic [15:0] GrantCnt0, GrantCnt1;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 Clk = ~Clk;

   alu_share_arbiter #(.ALU_LAT(LAT)) dut (
      .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
      .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB), .RspValid(RspValid),
      .RspReady(RspReady), .RspResult(RspResult), .RspZero(RspZero),
      .ALUControl(ALUControl), .ALUA(ALUA), .ALUB(ALUB),
      .ALUResult(ALUResult), .ALUZero(ALUZero), .Busy(Busy),
      .GrantCnt0(GrantCnt0), .GrantCnt1(GrantCnt1)
   );

   // Behavioural shared ALU (combinational; result valid within LAT=1).
   function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   assign ALUResult = alu_f(ALUControl, ALUA, ALUB);
   assign ALUZero   = (ALUResult == 32'd0);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      ReqValid[r]      = 1'b1;
      ReqOp[r*6 +: 6]  = op;
      ReqA[r*32 +: 32] = a;
      ReqB[r*32 +: 32] = b;
   endtask

   // Wait (bounded) for a response; n = cycles after the grant cycle.
   task automatic wait_rsp(input logic [1:0] exp_v, output int n);
      n = 1;
      while (RspValid == 2'b00 && n < 30) begin
         cyc();
         n++;
      end
      chk("rsp_valid", RspValid, exp_v);
   endtask

   // One operation from one requester with RspReady held high.
   task automatic run_single(input int r, input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] res, input logic z);
      int n;
      RspReady = 2'b11;
      set_req(r, op, a, b);
      #1;
      chk("grant", ReqReady, 2'b01 << r);
      cyc();
      ReqValid = 2'b00;
      chk("busy_exec", Busy, 1);
      chk("alu_ctl", ALUControl, op);
      chk("alu_a", ALUA, a);
      chk("alu_b", ALUB, b);
      wait_rsp(2'b01 << r, n);
      chk("result", RspResult, res);
      chk("zero", RspZero, z);
      // Grant cycle counts as cycle 1; response cycle is LAT+2.
      chk("latency", n + 1, LAT + 2);
      cyc();
      chk("idle_after", Busy, 0);
      chk("rspv_clear", RspValid, 0);
   endtask

   typedef struct {
      int          r;
      logic [5:0]  op;
      logic [31:0] a, b, res;
      logic        z;
   } vec_t;

   vec_t vt[8];
   logic [5:0] ops[5];

   logic        pend[2];
   logic [5:0]  pop[2];
   logic [31:0] pa[2], pb[2];
   logic        m_active;
   int          m_owner, m_grant_k, m_last, w, n;
   logic [31:0] m_res;

   initial begin
      ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT};
      vt[0] = '{0, OP_ADD, 32'd5,          32'd5,          32'd10,         1'b0};
      vt[1] = '{1, OP_SUB, 32'd9,          32'd4,          32'd5,          1'b0};
      vt[2] = '{0, OP_AND, 32'h0000_F0F0,  32'h0000_0F0F,  32'd0,          1'b1};
      vt[3] = '{1, OP_OR,  32'h0000_00A0,  32'h0000_000B,  32'h0000_00AB,  1'b0};
      vt[4] = '{0, OP_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
      vt[5] = '{1, OP_SLT, 32'd3,          32'hFFFF_FFFE,  32'd0,          1'b1};
      vt[6] = '{0, OP_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
      vt[7] = '{1, OP_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};

      Reset = 1'b1; ReqValid = 2'b00; RspReady = 2'b00;
      ReqOp = 12'h000; ReqA = 64'h0; ReqB = 64'h0;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_busy", Busy, 0);
      chk("rst_rspv", RspValid, 0);
      chk("rst_result", RspResult, 0);
      chk("rst_alu", {ALUControl, ALUA, ALUB[25:0]}, 0);
      chk("rst_cnt", {GrantCnt1, GrantCnt0}, 0);
      Reset = 1'b0;
      #1;
      chk("rst_ready", ReqReady, 0);
      cyc();

      // Table of single operations (first entry: ADD 5+5 straight after reset).
      for (int i = 0; i < 8; i++)
         run_single(vt[i].r, vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].z);

      // Simultaneous pair, twice: R0 must win each time (last grant was R1).
      for (int p = 0; p < 2; p++) begin
         RspReady = 2'b11;
         set_req(0, OP_SUB, 32'd5, 32'd3);
         set_req(1, OP_SUB, 32'd10, 32'd2);
         #1;
         chk("pair_first", ReqReady, 2'b01);
         cyc();
         ReqValid = 2'b10;
         #1;
         chk("pair_wait_rdy", ReqReady, 2'b00);
         wait_rsp(2'b01, n);
         chk("pair_r0", RspResult, 32'd2);
         cyc();
         #1;
         chk("pair_second", ReqReady, 2'b10);
         cyc();
         ReqValid = 2'b00;
         wait_rsp(2'b10, n);
         chk("pair_r1", RspResult, 32'd8);
         cyc();
      end

      // Stalled response: R1 SUB 7-7, RspReady[1] low for 5 cycles, R0 waiting.
      RspReady = 2'b11;
      set_req(1, OP_SUB, 32'd7, 32'd7);
      #1;
      chk("stall_grant", ReqReady, 2'b10);
      cyc();
      ReqValid = 2'b00;
      set_req(0, OP_ADD, 32'd1, 32'd2);
      RspReady = 2'b01;
      wait_rsp(2'b10, n);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_v", RspValid, 2'b10);
         chk("stall_res", RspResult, 0);
         chk("stall_z", RspZero, 1);
         chk("stall_rdy", ReqReady, 2'b00);
         chk("stall_busy", Busy, 1);
         cyc();
      end
      RspReady = 2'b10;
      #1;
      chk("hs_rdy", ReqReady, 2'b00);
      cyc();
      #1;
      chk("after_hs_grant", ReqReady, 2'b01);
      cyc();
      ReqValid = 2'b00;
      RspReady = 2'b11;
      wait_rsp(2'b01, n);
      chk("after_hs_res", RspResult, 32'd3);
      cyc();

      // Reset during EXEC of R0 AND 15&14.
      set_req(0, OP_AND, 32'd15, 32'd14);
      #1;
      chk("abort_grant", ReqReady, 2'b01);
      cyc();
      ReqValid = 2'b00;
      chk("abort_in_exec", Busy, 1);
      #2 Reset = 1'b1;
      #1;
      chk("abort_busy", Busy, 0);
      chk("abort_rspv", RspValid, 0);
      chk("abort_data", {RspResult, 5'b0, RspZero, ALUControl}, 0);
      chk("abort_alu", {ALUA, ALUB}, 0);
      chk("abort_cnt", {GrantCnt1, GrantCnt0}, 0);
      cyc();
      Reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("abort_no_rsp", {Busy, RspValid}, 0);
         cyc();
      end
      run_single(0, OP_AND, 32'd15, 32'd14, 32'd14, 1'b0);

      // Grant counters: 3 R0 grants (one above) and 2 R1 grants since reset.
      run_single(0, OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0);
      run_single(1, OP_OR, 32'd4, 32'd1, 32'd5, 1'b0);
      run_single(0, OP_SUB, 32'd4, 32'd4, 32'd0, 1'b1);
      run_single(1, OP_ADD, 32'd6, 32'd6, 32'd12, 1'b0);
`ifdef ALU_ARB_STATS_EN
      chk("gcnt0", GrantCnt0, 16'd3);
      chk("gcnt1", GrantCnt1, 16'd2);
`else
      chk("gcnt0", GrantCnt0, 16'd0);
      chk("gcnt1", GrantCnt1, 16'd0);
`endif

      // Randomized run against a transaction-level model.
      pend[0] = 1'b0; pend[1] = 1'b0;
      m_active = 1'b0; m_owner = 0; m_grant_k = 0; m_res = 32'd0;
      m_last = 1;  // last grant above went to R1
      for (int k = 0; k < 400; k++) begin
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && $urandom_range(0, 2) == 0) begin
               pend[r] = 1'b1;
               pop[r]  = ops[$urandom_range(0, 4)];
               pa[r]   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
               pb[r]   = ($urandom_range(0, 3) == 0) ? pa[r] : 32'($urandom_range(0, 20));
            end
         end
         ReqValid = {pend[1], pend[0]};
         ReqOp    = {pop[1], pop[0]};
         ReqA     = {pa[1], pa[0]};
         ReqB     = {pb[1], pb[0]};
         RspReady = 2'($urandom);
         #1;
         if (!m_active) begin
            w = -1;
            if (pend[0] && pend[1]) w = 1 - m_last;
            else if (pend[0])       w = 0;
            else if (pend[1])       w = 1;
            chk("rnd_ready", ReqReady, (w < 0) ? 2'b00 : (2'b01 << w));
            chk("rnd_busy_idle", Busy, 0);
            chk("rnd_rspv_idle", RspValid, 0);
            if (w >= 0) begin
               m_active  = 1'b1;
               m_owner   = w;
               m_grant_k = k;
               m_last    = w;
               m_res     = alu_f(pop[w], pa[w], pb[w]);
               pend[w]   = 1'b0;
            end
         end else begin
            chk("rnd_ready_busy", ReqReady, 0);
            chk("rnd_busy", Busy, 1);
            if (k >= m_grant_k + LAT + 1) begin
               chk("rnd_rspv", RspValid, 2'b01 << m_owner);
               chk("rnd_res", RspResult, m_res);
               chk("rnd_zero", RspZero, m_res == 32'd0);
               if (RspReady[m_owner]) m_active = 1'b0;
            end else begin
               chk("rnd_rspv_exec", RspValid, 0);
            end
         end
         cyc();
      end

      // Drain with a bounded wait.
      ReqValid = 2'b00;
      RspReady = 2'b11;
      for (int i = 0; i < 20 && Busy; i++) cyc();
      chk("drain_idle", Busy, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
